// File: rtl/mdu_core.sv
// Multi-cycle multiply/divide unit with HI/LO registers for the EX stage.
// Operands are latched on start; the product or quotient/remainder is formed
// combinationally from the latched copies and committed on the final busy edge.
module mdu_core #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned MUL_CYCLES = 5,
    parameter int unsigned DIV_CYCLES = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       mdu_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             read_sel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int unsigned MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int unsigned CW   = $clog2(MAXC + 1);

    // Counter load values: the op commits on the edge where the count is already zero.
    localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_CYCLES - 1);
    localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_CYCLES - 1);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_signed;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_busy;
    logic             r_done;

    logic [2*WIDTH-1:0] w_ax;
    logic [2*WIDTH-1:0] w_bx;
    logic [2*WIDTH-1:0] w_prod;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_ua;
    logic [WIDTH-1:0]   w_ub;
    logic [WIDTH-1:0]   w_ub_safe;
    logic               w_div_zero;
    logic [WIDTH-1:0]   w_uq;
    logic [WIDTH-1:0]   w_ur;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_rem;

    // Arithmetic on the latched operands; signed ops work on magnitudes then fix signs.
    always_comb begin
        w_ax       = r_signed ? {{WIDTH{r_a[WIDTH-1]}}, r_a} : {{WIDTH{1'b0}}, r_a};
        w_bx       = r_signed ? {{WIDTH{r_b[WIDTH-1]}}, r_b} : {{WIDTH{1'b0}}, r_b};
        w_prod     = w_ax * w_bx;

        w_a_neg    = r_signed & r_a[WIDTH-1];
        w_b_neg    = r_signed & r_b[WIDTH-1];
        w_ua       = w_a_neg ? (~r_a + WIDTH'(1)) : r_a;
        w_ub       = w_b_neg ? (~r_b + WIDTH'(1)) : r_b;
        w_div_zero = (r_b == '0);
        // Keep the divider defined when b==0; its output is discarded in that case.
        w_ub_safe  = w_div_zero ? WIDTH'(1) : w_ub;
        w_uq       = w_ua / w_ub_safe;
        w_ur       = w_ua % w_ub_safe;
        // MIN / -1 falls out naturally: |MIN| negated wraps back to MIN, remainder 0.
        w_quot     = (w_a_neg ^ w_b_neg) ? (~w_uq + WIDTH'(1)) : w_uq;
        w_rem      = w_a_neg ? (~w_ur + WIDTH'(1)) : w_ur;
    end

    // Control FSM, operand latches, HI/LO and registered busy/done.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_count  <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_signed <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        case (mdu_op)
                            OP_MULT, OP_MULTU: begin
                                r_state  <= S_MUL;
                                r_count  <= MUL_LOAD;
                                r_a      <= a;
                                r_b      <= b;
                                r_signed <= (mdu_op == OP_MULT);
                                r_busy   <= 1'b1;
                            end
                            OP_DIV, OP_DIVU: begin
                                r_state  <= S_DIV;
                                r_count  <= DIV_LOAD;
                                r_a      <= a;
                                r_b      <= b;
                                r_signed <= (mdu_op == OP_DIV);
                                r_busy   <= 1'b1;
                            end
                            OP_MTHI: r_hi <= a;
                            OP_MTLO: r_lo <= a;
                            default: ; // reserved ops are ignored
                        endcase
                    end
                end
                S_MUL: begin
                    if (r_count == '0) begin
                        r_hi    <= w_prod[2*WIDTH-1:WIDTH];
                        r_lo    <= w_prod[WIDTH-1:0];
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_count <= r_count - CW'(1);
                    end
                end
                S_DIV: begin
                    if (r_count == '0) begin
                        // Divide by zero still takes the full latency but leaves HI/LO alone.
                        if (!w_div_zero) begin
                            r_hi <= w_rem;
                            r_lo <= w_quot;
                        end
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_count <= r_count - CW'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = read_sel ? r_hi : r_lo;

endmodule
